// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: CPU, DMA and data-memory bus bundle; slave = arbiter side, master = requesters/memory side
interface dmem_arbiter_if #(
    parameter int AW   = 32,
    parameter int DW   = 32,
    parameter int LENW = 4
);
    logic            cpu_rd;
    logic            cpu_wr;
    logic [AW-1:0]   cpu_addr;
    logic [DW-1:0]   cpu_wdata;
    logic [DW-1:0]   cpu_rdata;
    logic            cpu_stall;
    logic            dma_req;
    logic [LENW-1:0] dma_len;
    logic            dma_valid;
    logic            dma_wr;
    logic [AW-1:0]   dma_addr;
    logic [DW-1:0]   dma_wdata;
    logic            dma_gnt;
    logic            dma_ack;
    logic [DW-1:0]   dma_rdata;
    logic            mem_rd;
    logic            mem_wr;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW-1:0]   mem_rdata;
    modport slave (
        input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
        input  dma_req, dma_len, dma_valid, dma_wr, dma_addr, dma_wdata,
        input  mem_rdata,
        output cpu_rdata, cpu_stall, dma_gnt, dma_ack, dma_rdata,
        output mem_rd, mem_wr, mem_addr, mem_wdata
    );
    modport master (
        output cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
        output dma_req, dma_len, dma_valid, dma_wr, dma_addr, dma_wdata,
        output mem_rdata,
        input  cpu_rdata, cpu_stall, dma_gnt, dma_ack, dma_rdata,
        input  mem_rd, mem_wr, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: CPU-priority data-memory arbiter with bounded DMA wait; ports clk, reset, bus (cpu_*, dma_*, mem_*)
module dmem_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int LENW     = 4,
    parameter int MAX_WAIT = 8
) (
    input logic          clk,
    input logic          reset,
    dmem_arbiter_if.slave bus
);
    localparam int WW = MAX_WAIT > 1 ? $clog2(MAX_WAIT) : 1;
    typedef enum logic {S_CPU, S_DMA} state_t;
    state_t          state, state_nx;
    logic [WW-1:0]   wait_cnt, wait_nx;
    logic [LENW-1:0] beat_cnt, beat_nx;
    logic            own, cpu_busy, wait_max, grant, last;
    assign own      = state == S_DMA;
    assign cpu_busy = bus.cpu_rd | bus.cpu_wr;
    assign wait_max = wait_cnt == WW'(MAX_WAIT - 1);
    assign grant    = bus.dma_req & (~cpu_busy | wait_max);
    assign last     = beat_cnt == '0;
    assign bus.dma_gnt   = own;
    assign bus.dma_ack   = own & bus.dma_valid;
    assign bus.dma_rdata = own ? bus.mem_rdata : DW'(0);
    assign bus.cpu_rdata = own ? DW'(0) : bus.mem_rdata;
    assign bus.cpu_stall = own & cpu_busy;
    assign bus.mem_addr  = AW'(own ? bus.dma_addr : bus.cpu_addr);
    assign bus.mem_wdata = own ? bus.dma_wdata : bus.cpu_wdata;
    assign bus.mem_wr    = own ? bus.dma_valid & bus.dma_wr : bus.cpu_wr;
    assign bus.mem_rd    = own ? bus.dma_valid & ~bus.dma_wr : bus.cpu_rd;
    always_comb begin
        state_nx = state;
        wait_nx  = '0;
        beat_nx  = beat_cnt;
        if (!own) begin
            state_nx = grant ? S_DMA : S_CPU;
            beat_nx  = grant ? bus.dma_len : beat_cnt;
            wait_nx  = grant || !bus.dma_req ? '0 : wait_max ? wait_cnt : wait_cnt + 1'b1;
        end else if (bus.dma_valid) begin
            state_nx = last ? S_CPU : S_DMA;
            beat_nx  = last ? beat_cnt : beat_cnt - 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_CPU;
            wait_cnt <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_nx;
            wait_cnt <= wait_nx;
            beat_cnt <= beat_nx;
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed-vector scoreboard bench for dmem_arbiter
module tb_dmem_arbiter;
    typedef struct {
        logic        g, a, s, mr, mw;
        logic [31:0] ma, dr, cr;
        logic [3:0]  b;
        logic [2:0]  w;
    } exp_t;
    logic clk = 1'b0;
    logic reset;
    logic [31:0] mem_arr [0:63];
    exp_t exp_q[$];
    logic [31:0] ack_q[$];
    exp_t mon_e;
    int pass_cnt = 0;
    int total_cnt = 0;
    dmem_arbiter_if #(.AW(32), .DW(32), .LENW(4)) bus();
    dmem_arbiter #(.AW(32), .DW(32), .LENW(4), .MAX_WAIT(8)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );
    always #5 clk = ~clk;
    initial for (int i = 0; i < 64; i++) mem_arr[i] <= (i == 4) ? 32'hDEADBEEF : (32'hA000_0000 | i);
    assign bus.mem_rdata = mem_arr[bus.mem_addr[7:2]];
    always @(posedge clk) if (bus.mem_wr === 1'b1) mem_arr[bus.mem_addr[7:2]] <= bus.mem_wdata;
    function automatic void chk(string n, logic [31:0] act, logic [31:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", n, act, req, $time);
    endfunction
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("dma_gnt",   32'(bus.dma_gnt),   32'(mon_e.g));
            chk("dma_ack",   32'(bus.dma_ack),   32'(mon_e.a));
            chk("cpu_stall", 32'(bus.cpu_stall), 32'(mon_e.s));
            chk("mem_rd",    32'(bus.mem_rd),    32'(mon_e.mr));
            chk("mem_wr",    32'(bus.mem_wr),    32'(mon_e.mw));
            chk("mem_addr",  bus.mem_addr,       mon_e.ma);
            chk("dma_rdata", bus.dma_rdata,      mon_e.dr);
            chk("cpu_rdata", bus.cpu_rdata,      mon_e.cr);
            chk("beat_cnt",  32'(dut.beat_cnt),  32'(mon_e.b));
            chk("wait_cnt",  32'(dut.wait_cnt),  32'(mon_e.w));
        end
        if (bus.dma_ack === 1'b1) begin
            if (ack_q.size() == 0) begin
                total_cnt++;
                $display("FAIL ack_unexpected: got dma_ack=1 expected 0 at %0t", $time);
            end else chk("ack_rdata", bus.dma_rdata, ack_q.pop_front());
        end
    end
    task automatic cpu(input logic rd, wr, input logic [31:0] addr, wd);
        bus.cpu_rd = rd; bus.cpu_wr = wr; bus.cpu_addr = addr; bus.cpu_wdata = wd;
    endtask
    task automatic dma(input logic req, input logic [3:0] len, input logic v, wr, input logic [31:0] addr, wd);
        bus.dma_req = req; bus.dma_len = len; bus.dma_valid = v; bus.dma_wr = wr; bus.dma_addr = addr; bus.dma_wdata = wd;
    endtask
    task automatic ex(input logic g, a, s, mr, mw, input logic [31:0] ma, dr, cr, input logic [3:0] b, input logic [2:0] w);
        exp_t e;
        e = '{g: g, a: a, s: s, mr: mr, mw: mw, ma: ma, dr: dr, cr: cr, b: b, w: w};
        exp_q.push_back(e);
        if (a) ack_q.push_back(dr);
        @(posedge clk);
        #1;
    endtask
    initial begin
        reset = 1'b1;
        cpu(0, 0, 0, 0); dma(0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        ex(0, 0, 0, 0, 0, 0, 0, 32'hA0000000, 0, 0);
        // 4-beat burst, CPU idle: W, W, R (sees earlier write), W
        dma(1, 3, 1, 1, 32'h40, 32'h11); ex(0, 0, 0, 0, 0, 0, 0, 32'hA0000000, 0, 0);
        dma(0, 3, 1, 1, 32'h40, 32'h11); ex(1, 1, 0, 0, 1, 32'h40, 32'hA0000010, 0, 3, 0);
        dma(0, 3, 1, 1, 32'h44, 32'h22); ex(1, 1, 0, 0, 1, 32'h44, 32'hA0000011, 0, 2, 0);
        dma(0, 3, 1, 0, 32'h40, 32'h00); ex(1, 1, 0, 1, 0, 32'h40, 32'h11, 0, 1, 0);
        dma(0, 3, 1, 1, 32'h48, 32'h33); ex(1, 1, 0, 0, 1, 32'h48, 32'hA0000012, 0, 0, 0);
        dma(0, 0, 0, 0, 0, 0); cpu(1, 0, 32'h48, 0); ex(0, 0, 0, 1, 0, 32'h48, 0, 32'h33, 0, 0);
        // CPU busy every cycle: forced grant on the 8th waiting edge, CPU write still served
        dma(1, 0, 0, 0, 0, 0); cpu(1, 0, 32'h44, 0);
        for (int k = 0; k < 7; k++) ex(0, 0, 0, 1, 0, 32'h44, 0, 32'h22, 0, 3'(k));
        cpu(0, 1, 32'h50, 32'h55); ex(0, 0, 0, 0, 1, 32'h50, 0, 32'hA0000014, 0, 7);
        cpu(1, 0, 32'h50, 0); dma(0, 0, 1, 0, 32'h50, 0); ex(1, 1, 1, 1, 0, 32'h50, 32'h55, 0, 0, 0);
        dma(0, 0, 0, 0, 0, 0); ex(0, 0, 0, 1, 0, 32'h50, 0, 32'h55, 0, 0);
        // 3-beat read burst with valid gaps 1,0,0,1,1 while CPU keeps requesting
        cpu(0, 0, 0, 0); dma(1, 2, 0, 0, 0, 0); ex(0, 0, 0, 0, 0, 0, 0, 32'hA0000000, 0, 0);
        cpu(1, 0, 32'h44, 0); dma(0, 2, 1, 0, 32'h10, 0); ex(1, 1, 1, 1, 0, 32'h10, 32'hDEADBEEF, 0, 2, 0);
        dma(0, 2, 0, 0, 32'h14, 0); ex(1, 0, 1, 0, 0, 32'h14, 32'hA0000005, 0, 1, 0);
        ex(1, 0, 1, 0, 0, 32'h14, 32'hA0000005, 0, 1, 0);
        dma(0, 2, 1, 0, 32'h14, 0); ex(1, 1, 1, 1, 0, 32'h14, 32'hA0000005, 0, 1, 0);
        dma(0, 2, 1, 0, 32'h18, 0); ex(1, 1, 1, 1, 0, 32'h18, 32'hA0000006, 0, 0, 0);
        dma(0, 0, 0, 0, 0, 0); ex(0, 0, 0, 1, 0, 32'h44, 0, 32'h22, 0, 0);
        // back-to-back 1-beat bursts: request held across the last beat is ignored
        cpu(0, 0, 0, 0); dma(1, 0, 1, 1, 32'h60, 32'h66); ex(0, 0, 0, 0, 0, 0, 0, 32'hA0000000, 0, 0);
        ex(1, 1, 0, 0, 1, 32'h60, 32'hA0000018, 0, 0, 0);
        dma(1, 0, 1, 1, 32'h64, 32'h77); ex(0, 0, 0, 0, 0, 0, 0, 32'hA0000000, 0, 0);
        dma(0, 0, 1, 1, 32'h64, 32'h77); ex(1, 1, 0, 0, 1, 32'h64, 32'hA0000019, 0, 0, 0);
        dma(0, 0, 0, 0, 0, 0); cpu(1, 0, 32'h60, 0); ex(0, 0, 0, 1, 0, 32'h60, 0, 32'h66, 0, 0);
        // reset after 2 of 5 beats abandons the burst
        cpu(0, 0, 0, 0); dma(1, 4, 1, 0, 32'h10, 0); ex(0, 0, 0, 0, 0, 0, 0, 32'hA0000000, 0, 0);
        dma(0, 4, 1, 0, 32'h10, 0); ex(1, 1, 0, 1, 0, 32'h10, 32'hDEADBEEF, 0, 4, 0);
        dma(0, 4, 1, 0, 32'h14, 0); ex(1, 1, 0, 1, 0, 32'h14, 32'hA0000005, 0, 3, 0);
        reset = 1'b1; cpu(1, 0, 32'h44, 0); dma(0, 4, 1, 0, 32'h18, 0); ex(1, 1, 1, 1, 0, 32'h18, 32'hA0000006, 0, 2, 0);
        reset = 1'b0; dma(0, 4, 1, 1, 32'h18, 32'h99); ex(0, 0, 0, 1, 0, 32'h44, 0, 32'h22, 0, 0);
        cpu(1, 0, 32'h18, 0); dma(0, 0, 0, 0, 0, 0); ex(0, 0, 0, 1, 0, 32'h18, 0, 32'hA0000006, 0, 0);
        @(negedge clk);
        chk("exp_q_drained", 32'(exp_q.size()), 0);
        chk("ack_q_drained", 32'(ack_q.size()), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters:
  - the pipeline MEM stage (CPU port), after the peripheral/memory address split;
  - a DMA/loader engine (e.g. the UART boot loader) that moves bursts of words.
- CPU has priority. A wait counter bounds DMA starvation.
- While the DMA owns the bus, any CPU access is held off with cpu_stall, which the pipeline uses to freeze its stage registers.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- LENW, 4, burst length field width; a burst is dma_len+1 beats (1..16).
- MAX_WAIT, 8, max cycles a pending dma_req waits before a forced grant (>=1).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cpu_rd  in  1  CPU MEM-stage read strobe.
- cpu_wr  in  1  CPU MEM-stage write strobe.
- cpu_addr  in  AW  CPU address.
- cpu_wdata  in  DW  CPU write data.
- cpu_rdata  out  DW  read data to CPU.
- cpu_stall  out  1  CPU access blocked this cycle; hold MEM stage.
- dma_req  in  1  DMA burst request; held high until dma_gnt.
- dma_len  in  LENW  beats-1; sampled on the grant edge.
- dma_valid  in  1  DMA beat present this cycle.
- dma_wr  in  1  beat is a write (0 = read).
- dma_addr  in  AW  beat address.
- dma_wdata  in  DW  beat write data.
- dma_gnt  out  1  DMA owns bus (registered).
- dma_ack  out  1  beat accepted this cycle.
- dma_rdata  out  DW  read data to DMA.
- mem_rd  out  1  to data memory.
- mem_wr  out  1  to data memory.
- mem_addr  out  AW  to data memory.
- mem_wdata  out  DW  to data memory.
- mem_rdata  in  DW  combinational read data from data memory.

Behaviour:
- Registered state: state (S_CPU/S_DMA), wait_cnt, beat_cnt (LENW bits).
- Reset, synchronous and active-high, applies at the next clk edge:
  - state=S_CPU, wait_cnt=0, beat_cnt=0, dma_gnt=0.
  - Combinational outputs then follow S_CPU rules.
  - Reset mid-burst abandons the burst. No dma_ack after that edge.
- S_CPU:
  - mem_* = cpu_*; cpu_rdata=mem_rdata; cpu_stall=0; dma_ack=0.
  - Grant condition at an edge: dma_req=1 AND (cpu_rd|cpu_wr)=0 OR wait_cnt==MAX_WAIT-1.
  - On grant: next state=S_DMA, beat_cnt<=dma_len, wait_cnt<=0.
  - Forced grant: the CPU access in that same cycle is still served.
  - Otherwise, if dma_req=1, wait_cnt increments, saturating at MAX_WAIT-1.
  - If dma_req=0, wait_cnt<=0.
- S_DMA:
  - dma_gnt=1.
  - mem_addr=dma_addr; mem_wdata=dma_wdata.
  - mem_wr=dma_valid&dma_wr; mem_rd=dma_valid&~dma_wr.
  - dma_ack=dma_valid (zero-latency accept); dma_rdata=mem_rdata.
  - cpu_stall=cpu_rd|cpu_wr; cpu_rdata=0.
  - Beat accounting:
    - Each acked beat decrements beat_cnt.
    - The beat acked with beat_cnt==0 is the last one; next state=S_CPU.
    - dma_valid=0 cycles consume no beat; the bus stays held with no timeout.
- Fairness:
  - After a burst, state is S_CPU for at least one cycle.
  - Any dma_req seen on the final-beat edge is ignored. Counting restarts in S_CPU.
- No combinational path from dma_req to mem_* or cpu_stall. Ownership changes only on clk edges.
- dma_rdata is 0 in S_CPU.
- mem_wr is never asserted by the non-owner.
- Max CPU stall per burst equals the burst's DMA cycle count.
- Max DMA wait is MAX_WAIT cycles from dma_req rise to grant edge; dma_gnt rises the cycle after that edge.

Test Plan:
- CPU idle, dma_req with dma_len=3 and dma_valid=1 continuously:
  - dma_gnt rises 1 cycle after the request.
  - 4 acks follow; dma_gnt falls after the 4th beat.
  - mem_wr pulses only on DMA write beats.
- CPU busy every cycle, dma_req held, MAX_WAIT=8:
  - grant edge at cycle 8 of waiting; the CPU access on that cycle still completes.
  - next cycle cpu_stall=1 while the CPU keeps requesting.
- Burst with dma_valid gaps, pattern 1,0,0,1:
  - beat_cnt changes only on acked beats.
  - dma_gnt stays high across the gaps; cpu_stall stays high throughout.
- DMA read of address 0x10 holding 0xDEADBEEF: dma_rdata=0xDEADBEEF in the ack cycle; cpu_rdata=0.
- Back-to-back dma_req held through the end of a 1-beat burst: at least one S_CPU cycle with dma_gnt=0 before the next grant.
- reset=1 mid-burst, after 2 of 5 beats: next cycle dma_gnt=0, dma_ack=0, wait_cnt=0, mem_* follow CPU.
